// File: rtl/hazard_pkg.sv
// Shared definitions for the destination-register hazard tracker.
package hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Hazard-relevant fields carried by one pipeline slot.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             regwrite;
    logic             memread;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // A slot writes register r only when it is live, writes the regfile and r is not $0.
  function automatic logic writes_reg(input logic             valid,
                                      input logic             regwrite,
                                      input logic [REG_W-1:0] dest,
                                      input logic [REG_W-1:0] r);
    return valid && regwrite && (dest == r) && (r != '0);
  endfunction

endpackage

// File: rtl/dest_reg_hazard_tracker_fwd_select_unit.sv
// Picks the EX operand source for one register: MEM result, WB result or regfile.
module fwd_select_unit
  import hazard_pkg::*;
(
  input  logic             ex_valid,
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_regwrite,
  output logic [1:0]       sel
);

  // Nearest producer wins; a load still in MEM has no data yet, so it never forwards.
  always_comb begin
    sel = FWD_RF;
    if (ex_valid && src_used) begin
      if (writes_reg(mem_valid, mem_regwrite, mem_dest, src) && !mem_memread) begin
        sel = FWD_MEM;
      end else if (writes_reg(wb_valid, wb_regwrite, wb_dest, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/dest_reg_hazard_tracker.sv
// Shadows the EX/MEM/WB destination fields to produce the load-use stall and
// the EX operand forwarding selects, plus a saturating stall counter.
module dest_reg_hazard_tracker #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             IdValid,
  input  logic [REG_W-1:0] IdDestReg,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic             IdUsesRs,
  input  logic             IdUsesRt,
  input  logic             Flush,
  output logic             Stall,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] StallCount
);

  import hazard_pkg::*;

  slot_t            ex_slot;
  slot_t            mem_slot;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic             ex_uses_rs;
  logic             ex_uses_rt;

  // WB never needs memread: a load that has reached WB is an ordinary forward source.
  logic             wb_valid;
  logic [REG_W-1:0] wb_dest;
  logic             wb_regwrite;

  logic             ex_hits_rs;
  logic             ex_hits_rt;

  // Load in EX whose destination is a source the decode instruction actually reads.
  always_comb begin
    ex_hits_rs = writes_reg(ex_slot.valid, ex_slot.regwrite, ex_slot.dest, IdRs) && IdUsesRs;
    ex_hits_rt = writes_reg(ex_slot.valid, ex_slot.regwrite, ex_slot.dest, IdRt) && IdUsesRt;
    Stall      = IdValid && !Flush && ex_slot.valid && ex_slot.memread &&
                 (ex_hits_rs || ex_hits_rt);
  end

  // Slots advance every cycle; a stalled or flushed decode becomes a bubble in EX.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_slot     <= SLOT_BUBBLE;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_uses_rs  <= 1'b0;
      ex_uses_rt  <= 1'b0;
      mem_slot    <= SLOT_BUBBLE;
      wb_valid    <= 1'b0;
      wb_dest     <= '0;
      wb_regwrite <= 1'b0;
    end else begin
      wb_valid    <= mem_slot.valid;
      wb_dest     <= mem_slot.dest;
      wb_regwrite <= mem_slot.regwrite;
      mem_slot    <= ex_slot;
      if (IdValid && !Stall && !Flush) begin
        ex_slot.valid    <= 1'b1;
        ex_slot.dest     <= IdDestReg;
        ex_slot.regwrite <= IdRegWrite;
        ex_slot.memread  <= IdMemRead;
        ex_rs            <= IdRs;
        ex_rt            <= IdRt;
        ex_uses_rs       <= IdUsesRs;
        ex_uses_rt       <= IdUsesRt;
      end else begin
        ex_slot    <= SLOT_BUBBLE;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_uses_rs <= 1'b0;
        ex_uses_rt <= 1'b0;
      end
    end
  end

  // Count stall cycles, holding at all-ones.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

  fwd_select_unit u_fwd_a (
    .ex_valid     (ex_slot.valid),
    .src          (ex_rs),
    .src_used     (ex_uses_rs),
    .mem_valid    (mem_slot.valid),
    .mem_dest     (mem_slot.dest),
    .mem_regwrite (mem_slot.regwrite),
    .mem_memread  (mem_slot.memread),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .wb_regwrite  (wb_regwrite),
    .sel          (ForwardA)
  );

  fwd_select_unit u_fwd_b (
    .ex_valid     (ex_slot.valid),
    .src          (ex_rt),
    .src_used     (ex_uses_rt),
    .mem_valid    (mem_slot.valid),
    .mem_dest     (mem_slot.dest),
    .mem_regwrite (mem_slot.regwrite),
    .mem_memread  (mem_slot.memread),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .wb_regwrite  (wb_regwrite),
    .sel          (ForwardB)
  );

endmodule

// File: tb/tb_dest_reg_hazard_tracker.sv
// Scripted pipeline scenarios; expectations are queued as each decode cycle is
// driven and compared against the DUT at the following falling edge.
module tb_dest_reg_hazard_tracker;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       IdValid;
  logic [4:0] IdDestReg;
  logic       IdRegWrite;
  logic       IdMemRead;
  logic [4:0] IdRs;
  logic [4:0] IdRt;
  logic       IdUsesRs;
  logic       IdUsesRt;
  logic       Flush;
  logic       Stall;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic [15:0] StallCount;

  logic       stall_sat;
  logic [1:0] fa_sat;
  logic [1:0] fb_sat;
  logic [3:0] cnt_sat;

  always #5 Clk = ~Clk;

  dest_reg_hazard_tracker dut (
    .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdDestReg(IdDestReg),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdRs(IdRs), .IdRt(IdRt),
    .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt), .Flush(Flush), .Stall(Stall),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .StallCount(StallCount)
  );

  // Narrow counter copy so saturation is reachable in a few dozen cycles.
  dest_reg_hazard_tracker #(.CNT_W(4)) dut_sat (
    .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdDestReg(IdDestReg),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdRs(IdRs), .IdRt(IdRt),
    .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt), .Flush(Flush), .Stall(stall_sat),
    .ForwardA(fa_sat), .ForwardB(fb_sat), .StallCount(cnt_sat)
  );

  typedef struct {
    string       tag;
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stalls = 0;
  logic prev_rst = 1'b1;
  logic prev_stall = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one decode cycle and queue what the DUT must show during it.
  task automatic step(input string tag, input logic rst, input logic v, input int dest,
                      input logic rw, input logic mr, input int rs, input int rt,
                      input logic urs, input logic urt, input logic fl,
                      input logic e_stall, input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    @(posedge Clk);
    if (prev_rst) stalls = 0;
    else if (prev_stall && stalls < 65535) stalls++;
    #1;
    Rst        = rst;
    IdValid    = v;
    IdDestReg  = dest[4:0];
    IdRegWrite = rw;
    IdMemRead  = mr;
    IdRs       = rs[4:0];
    IdRt       = rt[4:0];
    IdUsesRs   = urs;
    IdUsesRt   = urt;
    Flush      = fl;
    e.tag   = tag;
    e.stall = e_stall;
    e.fa    = e_fa;
    e.fb    = e_fb;
    e.cnt   = stalls[15:0];
    e.cnt_s = (stalls > 15) ? 4'hF : stalls[3:0];
    sb.push_back(e);
    prev_rst   = rst;
    prev_stall = e_stall;
  endtask

  task automatic bubble(input string tag, input logic [1:0] e_fa, input logic [1:0] e_fb);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_fa, e_fb);
  endtask

  // Compare queued expectations mid-cycle, away from the rising edge.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val({e.tag, ".stall"}, 32'(Stall), 32'(e.stall));
      check_val({e.tag, ".fa"}, 32'(ForwardA), 32'(e.fa));
      check_val({e.tag, ".fb"}, 32'(ForwardB), 32'(e.fb));
      check_val({e.tag, ".cnt"}, 32'(StallCount), 32'(e.cnt));
      check_val({e.tag, ".cnt_sat"}, 32'(cnt_sat), 32'(e.cnt_s));
    end
  end

  initial begin
    Rst = 1'b1; IdValid = 1'b1; IdDestReg = 5'd3; IdRegWrite = 1'b1; IdMemRead = 1'b1;
    IdRs = 5'd3; IdRt = 5'd3; IdUsesRs = 1'b1; IdUsesRt = 1'b1; Flush = 1'b0;

    //    tag         rst v  dst rw mr rs rt urs urt fl  stall fa     fb
    step("rst1",      1, 1,  3, 1, 1, 3, 3, 1, 1, 0,  0, 2'b00, 2'b00);
    step("rst2",      1, 1,  3, 1, 1, 3, 3, 1, 1, 0,  0, 2'b00, 2'b00);

    step("add3",      0, 1,  3, 1, 0, 1, 2, 1, 1, 0,  0, 2'b00, 2'b00);
    step("sub_rs3",   0, 1,  4, 1, 0, 3, 1, 1, 1, 0,  0, 2'b00, 2'b00);
    bubble("sub_ex",  2'b01, 2'b00);
    bubble("b4",      2'b00, 2'b00);

    step("add6",      0, 1,  6, 1, 0, 1, 2, 1, 1, 0,  0, 2'b00, 2'b00);
    step("unrel",     0, 1,  8, 1, 0, 1, 2, 1, 1, 0,  0, 2'b00, 2'b00);
    step("or_rs6",    0, 1,  9, 1, 0, 6, 0, 1, 1, 0,  0, 2'b00, 2'b00);
    bubble("or_ex",   2'b10, 2'b00);
    bubble("b9",      2'b00, 2'b00);
    bubble("b10",     2'b00, 2'b00);

    step("lw5",       0, 1,  5, 1, 1, 1, 5, 1, 0, 0,  0, 2'b00, 2'b00);
    step("lu_stall",  0, 1, 10, 1, 0, 2, 5, 1, 1, 0,  1, 2'b00, 2'b00);
    step("lu_hold",   0, 1, 10, 1, 0, 2, 5, 1, 1, 0,  0, 2'b00, 2'b00);
    bubble("lu_ex",   2'b00, 2'b10);
    bubble("b15",     2'b00, 2'b00);

    step("add0",      0, 1,  0, 1, 0, 1, 2, 1, 1, 0,  0, 2'b00, 2'b00);
    step("lw0",       0, 1,  0, 1, 1, 1, 0, 1, 0, 0,  0, 2'b00, 2'b00);
    step("rd0_id",    0, 1, 11, 1, 0, 0, 0, 1, 1, 0,  0, 2'b00, 2'b00);
    bubble("rd0_ex",  2'b00, 2'b00);
    bubble("b20",     2'b00, 2'b00);
    bubble("b21",     2'b00, 2'b00);

    step("add7a",     0, 1,  7, 1, 0, 1, 2, 1, 1, 0,  0, 2'b00, 2'b00);
    step("add7b",     0, 1,  7, 1, 0, 1, 2, 1, 1, 0,  0, 2'b00, 2'b00);
    step("rd7_id",    0, 1, 12, 1, 0, 7, 7, 1, 1, 0,  0, 2'b00, 2'b00);
    bubble("prio_ex", 2'b01, 2'b01);
    bubble("b26",     2'b00, 2'b00);

    step("lw5f",      0, 1,  5, 1, 1, 1, 5, 1, 0, 0,  0, 2'b00, 2'b00);
    step("flush",     0, 1, 10, 1, 0, 2, 5, 1, 1, 1,  0, 2'b00, 2'b00);
    bubble("flush_ex", 2'b00, 2'b00);

    step("lw5r",      0, 1,  5, 1, 1, 1, 5, 1, 0, 0,  0, 2'b00, 2'b00);
    step("rst_stall", 1, 1, 10, 1, 0, 5, 0, 1, 0, 0,  1, 2'b00, 2'b00);
    step("post_rst",  0, 1, 10, 1, 0, 5, 0, 1, 0, 0,  0, 2'b00, 2'b00);
    bubble("post_ex", 2'b00, 2'b00);

    step("sat_pre",   0, 1,  5, 1, 1, 1, 0, 1, 0, 0,  0, 2'b00, 2'b00);
    for (int i = 0; i < 18; i++) begin
      step($sformatf("sat_s%0d", i), 0, 1, 5, 1, 1, 5, 0, 1, 0, 0, 1,
           (i == 0) ? 2'b00 : 2'b10, 2'b00);
      step($sformatf("sat_n%0d", i), 0, 1, 5, 1, 1, 5, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    end
    bubble("sat_end1", 2'b10, 2'b00);
    bubble("sat_end2", 2'b00, 2'b00);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge Clk);
    #1;
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
